// File: rtl/axis_keep_packer.sv
// AXI-Stream byte packer: squeezes null (tkeep=0) bytes out of a stream so every
// beat is full except the last beat of a packet, which is low-aligned.
module axis_keep_packer #(
  parameter int AXIS_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    sresetn,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]   axis_i_tkeep,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES-1:0]   axis_o_tkeep,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata
);

  localparam int DEPTH = 2 * AXIS_BYTES;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    buf_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          last_pending_q, last_pending_d;
  logic          i_fire, o_fire;

  // Handshakes depend only on registered state, so input never reaches output combinationally.
  assign axis_i_tready = sresetn && !last_pending_q && (int'(count_q) <= AXIS_BYTES);
  assign axis_o_tvalid = sresetn && ((int'(count_q) >= AXIS_BYTES) || last_pending_q);
  assign axis_o_tlast  = sresetn && last_pending_q && (int'(count_q) <= AXIS_BYTES);

  assign i_fire = axis_i_tvalid && axis_i_tready;
  assign o_fire = axis_o_tvalid && axis_o_tready;

  always_comb begin
    axis_o_tkeep = '0;
    axis_o_tdata = '0;
    for (int k = 0; k < AXIS_BYTES; k++) begin
      if (sresetn && (int'(count_q) > k)) begin
        axis_o_tkeep[k]       = 1'b1;
        axis_o_tdata[8*k +: 8] = buf_q[k];
      end
    end
  end

  // Shift out first, then append kept bytes at the post-shift fill level.
  always_comb begin
    int pos;
    buf_d          = buf_q;
    last_pending_d = last_pending_q;
    pos            = int'(count_q);

    if (o_fire) begin
      for (int j = 0; j < AXIS_BYTES; j++) begin
        buf_d[j]              = buf_q[j + AXIS_BYTES];
        buf_d[j + AXIS_BYTES] = 8'h00;
      end
      pos = (pos >= AXIS_BYTES) ? pos - AXIS_BYTES : 0;
      if (axis_o_tlast) begin
        last_pending_d = 1'b0;
      end
    end

    if (i_fire) begin
      for (int k = 0; k < AXIS_BYTES; k++) begin
        if (axis_i_tkeep[k]) begin
          for (int j = 0; j < DEPTH; j++) begin
            if (j == pos) begin
              buf_d[j] = axis_i_tdata[8*k +: 8];
            end
          end
          pos = pos + 1;
        end
      end
      if (axis_i_tlast) begin
        last_pending_d = 1'b1;
      end
    end

    count_d = CW'(pos);
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      for (int j = 0; j < DEPTH; j++) begin
        buf_q[j] <= 8'h00;
      end
      count_q        <= '0;
      last_pending_q <= 1'b0;
    end else begin
      buf_q          <= buf_d;
      count_q        <= count_d;
      last_pending_q <= last_pending_d;
    end
  end

endmodule
